// File: rtl/uart_transmit.sv
// uart_transmit
//   Baud-rate-clocked UART transmitter. Each accepted request is serialised
//   as one frame: a low start bit, BITWIDTH data bits LSB first, and a high
//   stop bit. One clock edge equals one bit time; there is no internal
//   divider. A single-cycle done pulse follows the stop bit.
//
// Parameters
//   BITWIDTH  data bits per frame (>= 1)
//
// Ports
//   clk    bit clock, rising edge active
//   rst    synchronous active-high reset; aborts any frame in flight
//   en     clock enable; when low every register holds
//   start  transmit request, only honoured while idle
//   in     parallel word, captured on the accepting edge
//   out    serial TX line, idles high
//   done   one-cycle pulse after the stop bit
//   busy   high from the start bit through the stop bit
module uart_transmit #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic [BITWIDTH-1:0] in,
  output logic                out,
  output logic                done,
  output logic                busy
);

  localparam int unsigned CNT_W = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITWIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                out_q,   out_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;

  // Outputs are computed one state ahead so that each register already
  // holds the value belonging to the state being entered.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE: begin
        out_d  = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          state_d = S_START;
          shift_d = in;
          cnt_d   = '0;
          out_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        // The shift register presents the next bit in position 0.
        state_d = S_DATA;
        out_d   = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end

      S_DATA: begin
        if (cnt_q == LAST_BIT) begin
          state_d = S_STOP;
          out_d   = 1'b1;
        end else begin
          out_d   = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        state_d = S_DONE;
        out_d   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
        out_d   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        out_d   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_transmit.sv
module tb_uart_transmit;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          start = 1'b0;
  logic [BW-1:0] in = '0;
  logic          out, done, busy;

  int checks = 0;
  int errors = 0;

  uart_transmit #(.BITWIDTH(BW)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .start(start),
    .in   (in),
    .out  (out),
    .done (done),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position since acceptance (-1 = idle).
  // Position 0 start bit, 1..BW data bits, BW+1 stop bit, BW+2 done cycle.
  int          m_pos = -1;
  logic [BW-1:0] m_data = '0;
  bit          m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pos   = -1;
      m_valid = 1;
    end else if (en) begin
      if (m_pos < 0) begin
        if (start) begin
          m_pos  = 0;
          m_data = in;
        end
      end else if (m_pos == BW + 2) begin
        m_pos = -1;
      end else begin
        m_pos++;
      end
    end
  end

  function automatic logic [2:0] model_outs(input int pos, input logic [BW-1:0] d);
    // {out, busy, done}
    if (pos < 0)            return 3'b100;
    else if (pos == 0)      return 3'b010;
    else if (pos <= BW)     return {d[pos-1], 2'b10};
    else if (pos == BW + 1) return 3'b110;
    else                    return 3'b101;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      logic [2:0] e;
      e = model_outs(m_pos, m_data);
      check(out  == e[2], "model_out",  out,  e[2]);
      check(busy == e[1], "model_busy", busy, e[1]);
      check(done == e[0], "model_done", done, e[0]);
    end
  end

  // Called at a negedge. Starts a frame, records out while busy (bounded),
  // optionally pokes start/in or drops en mid-frame, then checks the done
  // cycle against literal expectations.
  task automatic run_frame(input logic [BW-1:0] d, input int poke_at,
                           input int en_off_at, input int en_off_len,
                           input logic [31:0] exp_bits, input int exp_len,
                           input string name);
    int n;
    logic [31:0] got;
    start = 1'b1;
    in    = d;
    @(negedge clk);
    start = 1'b0;
    n   = 0;
    got = '0;
    for (int cyc = 0; cyc < 40 && busy; cyc++) begin
      got = {got[30:0], out};
      n++;
      if (poke_at >= 0 && cyc == poke_at) begin
        start = 1'b1;
        in    = '1;
      end else if (poke_at >= 0 && cyc == poke_at + 1) begin
        start = 1'b0;
      end
      if (en_off_at >= 0 && cyc == en_off_at) en = 1'b0;
      else if (en_off_at >= 0 && cyc == en_off_at + en_off_len) en = 1'b1;
      @(negedge clk);
    end
    check(n == exp_len, {name, "_busy_len"}, n, exp_len);
    check(got == exp_bits, {name, "_bits"}, got, exp_bits);
    check(done == 1'b1 && busy == 1'b0 && out == 1'b1, {name, "_done_cycle"},
          {done, busy, out}, 3'b101);
    @(negedge clk);
    check(done == 1'b0 && busy == 1'b0 && out == 1'b1, {name, "_after_done"},
          {done, busy, out}, 3'b001);
  endtask

  initial begin
    // Reset held for two edges.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check({out, busy, done} == 3'b100, "reset_state", {out, busy, done}, 3'b100);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(out == 1'b1 && busy == 1'b0, "idle_hold", {out, busy}, 2'b10);
    end

    // 0x55 then 0x96 back to back (out listed first-to-last, MSB first here).
    run_frame(8'h55, -1, -1, 0, 32'b0101010101, 10, "f55");
    run_frame(8'h96, -1, -1, 0, 32'b0011010011, 10, "f96");

    // Start pulsed during data bit 2 with in changed to 0xFF: frame unchanged.
    run_frame(8'hA3, 3, -1, 0, 32'b0110001011, 10, "fA3_poke");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check(busy == 1'b0 && done == 1'b0, "no_second_frame", {busy, done}, 2'b00);
    end

    // en low for 3 cycles while data bit 4 is on the line.
    run_frame(8'h0F, -1, 5, 3, 32'b0111100000001, 13, "f0F_en");

    // Reset during data bit 2 aborts the frame without a done pulse.
    start = 1'b1;
    in    = 8'hC6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check(busy == 1'b1, "pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({out, busy, done} == 3'b100, "abort_state", {out, busy, done}, 3'b100);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check(done == 1'b0 && busy == 1'b0, "abort_no_done", {done, busy}, 2'b00);
    end
    // 0xC6 LSB first: 0,1,1,0,0,0,1,1
    run_frame(8'hC6, -1, -1, 0, 32'b0011000111, 10, "fC6_after_abort");

    // Randomised traffic, checked every cycle by the model compare process.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      in    = BW'($urandom);
      en    = ($urandom_range(0, 7) != 0);
      rst   = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    en    = 1'b1;
    rst   = 1'b0;
    repeat (2 * BW + 8) @(negedge clk);
    check(busy == 1'b0 && out == 1'b1, "final_idle", {busy, out}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
